// File: rtl/priv_trap_pkg.sv
// Shared types and constants for the trap/interrupt sequencer.
//   trap_state_t : sequencer state encoding
//   MTVEC_*      : mtvec mode field values
//   cause_width  : width of the cause index, ceil(log2(max(n_irq, n_exc)))
package priv_trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        COMMIT = 2'd2,
        RET    = 2'd3
    } trap_state_t;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    function automatic int cause_width(input int n_irq, input int n_exc);
        int m;
        m = (n_irq > n_exc) ? n_irq : n_exc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/priv_prio_enc.sv
// Lowest-index-first priority encoder.
//   req    : request vector
//   valid  : any request set
//   index  : index of the lowest set request (0 when none)
//   onehot : one-hot of the winning request (0 when none)
module priv_prio_enc #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    always_comb begin
        valid  = |req;
        index  = '0;
        onehot = '0;
        // Scan from the top down so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                index     = IW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priv_trap_sequencer.sv
// Trap/interrupt sequencer between pipeline hazard logic and the CSR file.
// Latches interrupt edges into pending bits, picks the highest-priority
// trap (exceptions over interrupts, lowest index first), waits for the
// pipeline to drain, then emits one-cycle CSR update and PC redirect strobes.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   irq_src/irq_en/global_ie interrupt lines, enables, global enable
//   clear_pending            software clear of pending bits
//   exc_src/exc_pc/exc_tval  exception flags, PC and trap value
//   pipe_clear               pipeline drained, redirect allowed
//   mret                     return request pulse
//   mtvec_base/mtvec_mode    trap vector configuration
//   mepc_in                  current mepc, return target
//   pending                  latched pending bits
//   trap_rup                 strobe: write mcause/mepc/mtval/mstatus
//   cause_intr/cause_code    latched cause
//   epc_out/tval_out         latched mepc/mtval write values
//   insert_pc/priv_pc        PC redirect strobe and target
//   busy                     sequencer not idle
//
// state  | meaning
// IDLE   | waiting for a trap or mret
// DRAIN  | cause latched, waiting for pipe_clear
// COMMIT | one cycle: CSR update and redirect to trap vector
// RET    | one cycle: redirect to mepc
module priv_trap_sequencer
    import priv_trap_pkg::*;
#(
    parameter int NUM_IRQ     = 16,
    parameter int NUM_EXC     = 16,
    parameter int XLEN        = 32,
    parameter int VECTORED_EN = 1
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic [NUM_IRQ-1:0]                       irq_src,
    input  logic [NUM_IRQ-1:0]                       irq_en,
    input  logic                                     global_ie,
    input  logic [NUM_IRQ-1:0]                       clear_pending,
    input  logic [NUM_EXC-1:0]                       exc_src,
    input  logic [XLEN-1:0]                          exc_pc,
    input  logic [XLEN-1:0]                          exc_tval,
    input  logic                                     pipe_clear,
    input  logic                                     mret,
    input  logic [XLEN-1:0]                          mtvec_base,
    input  logic [1:0]                               mtvec_mode,
    input  logic [XLEN-1:0]                          mepc_in,
    output logic [NUM_IRQ-1:0]                       pending,
    output logic                                     trap_rup,
    output logic                                     cause_intr,
    output logic [cause_width(NUM_IRQ, NUM_EXC)-1:0] cause_code,
    output logic [XLEN-1:0]                          epc_out,
    output logic [XLEN-1:0]                          tval_out,
    output logic                                     insert_pc,
    output logic [XLEN-1:0]                          priv_pc,
    output logic                                     busy
);

    localparam int CW  = cause_width(NUM_IRQ, NUM_EXC);
    localparam int IIW = $clog2(NUM_IRQ);
    localparam int EIW = $clog2(NUM_EXC);

    trap_state_t          state_q, state_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   irq_src_q;
    logic [NUM_IRQ-1:0]   taken_q, taken_d;
    logic                 cause_intr_q, cause_intr_d;
    logic [CW-1:0]        cause_code_q, cause_code_d;
    logic [XLEN-1:0]      epc_q, epc_d;
    logic [XLEN-1:0]      tval_q, tval_d;
    logic [XLEN-1:0]      priv_pc_q, priv_pc_d;

    logic                 exc_valid;
    logic [EIW-1:0]       exc_index;
    logic [NUM_EXC-1:0]   unused_exc_onehot;
    logic                 irq_valid;
    logic [IIW-1:0]       irq_index;
    logic [NUM_IRQ-1:0]   irq_onehot;
    logic                 irq_elig;
    logic [NUM_IRQ-1:0]   taken;
    logic [XLEN-1:0]      base_addr;
    logic [XLEN-1:0]      vec_addr;
    logic                 use_vec;

    priv_prio_enc #(.N(NUM_EXC), .IW(EIW)) u_exc_enc (
        .req    (exc_src),
        .valid  (exc_valid),
        .index  (exc_index),
        .onehot (unused_exc_onehot)
    );

    priv_prio_enc #(.N(NUM_IRQ), .IW(IIW)) u_irq_enc (
        .req    (pending_q & irq_en),
        .valid  (irq_valid),
        .index  (irq_index),
        .onehot (irq_onehot)
    );

    assign irq_elig  = global_ie & irq_valid;
    // taken_q remembers which IRQ was latched; it is only applied in COMMIT.
    assign taken     = (state_q == COMMIT) ? taken_q : '0;
    assign base_addr = mtvec_base & ~XLEN'(3);
    assign vec_addr  = base_addr + (XLEN'(cause_code_q) << 2);
    assign use_vec   = (VECTORED_EN != 0) && (mtvec_mode == MTVEC_VECTORED) && cause_intr_q;

    always_comb begin
        state_d      = state_q;
        taken_d      = taken_q;
        cause_intr_d = cause_intr_q;
        cause_code_d = cause_code_q;
        epc_d        = epc_q;
        tval_d       = tval_q;
        trap_rup     = 1'b0;
        insert_pc    = 1'b0;
        priv_pc      = priv_pc_q;

        // A fresh edge overrides a clear or take of the same bit.
        pending_d = (pending_q & ~clear_pending & ~taken) | (irq_src & ~irq_src_q);

        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    cause_intr_d = 1'b0;
                    cause_code_d = CW'(exc_index);
                    epc_d        = exc_pc;
                    tval_d       = exc_tval;
                    taken_d      = '0;
                    state_d      = DRAIN;
                end else if (irq_elig) begin
                    cause_intr_d = 1'b1;
                    cause_code_d = CW'(irq_index);
                    epc_d        = exc_pc;
                    tval_d       = '0;
                    taken_d      = irq_onehot;
                    state_d      = DRAIN;
                end else if (mret) begin
                    state_d = RET;
                end
            end
            DRAIN: begin
                // An exception preempts a latched interrupt, which then
                // stays pending because taken_d is dropped.
                if (exc_valid && cause_intr_q) begin
                    cause_intr_d = 1'b0;
                    cause_code_d = CW'(exc_index);
                    epc_d        = exc_pc;
                    tval_d       = exc_tval;
                    taken_d      = '0;
                end
                if (pipe_clear) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                trap_rup  = 1'b1;
                insert_pc = 1'b1;
                priv_pc   = use_vec ? vec_addr : base_addr;
                state_d   = IDLE;
            end
            RET: begin
                insert_pc = 1'b1;
                priv_pc   = mepc_in;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        priv_pc_d = priv_pc;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            irq_src_q    <= '0;
            taken_q      <= '0;
            cause_intr_q <= 1'b0;
            cause_code_q <= '0;
            epc_q        <= '0;
            tval_q       <= '0;
            priv_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            irq_src_q    <= irq_src;
            taken_q      <= taken_d;
            cause_intr_q <= cause_intr_d;
            cause_code_q <= cause_code_d;
            epc_q        <= epc_d;
            tval_q       <= tval_d;
            priv_pc_q    <= priv_pc_d;
        end
    end

    assign pending    = pending_q;
    assign cause_intr = cause_intr_q;
    assign cause_code = cause_code_q;
    assign epc_out    = epc_q;
    assign tval_out   = tval_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_priv_trap_sequencer.sv
// Bench for priv_trap_sequencer: directed scenarios with literal expectations,
// then randomized stimulus; a behavioural model is compared every cycle.
module tb_priv_trap_sequencer;

    logic        CLK;
    logic        RST;
    logic [15:0] irq_src, irq_en, clear_pending, pending;
    logic        global_ie;
    logic [15:0] exc_src;
    logic [31:0] exc_pc, exc_tval, mtvec_base, mepc_in;
    logic        pipe_clear, mret;
    logic [1:0]  mtvec_mode;
    logic        trap_rup, cause_intr, insert_pc, busy;
    logic [3:0]  cause_code;
    logic [31:0] epc_out, tval_out, priv_pc;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a trap is "in flight" until the pipe drains,
    // then produces exactly one commit cycle; mret produces one return cycle.
    bit          m_inflight, m_commit, m_ret, m_intr;
    int          m_code;
    logic [31:0] m_epc, m_tval;
    logic [15:0] m_pend, m_prev;

    priv_trap_sequencer dut (
        .CLK(CLK), .RST(RST),
        .irq_src(irq_src), .irq_en(irq_en), .global_ie(global_ie),
        .clear_pending(clear_pending),
        .exc_src(exc_src), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .pipe_clear(pipe_clear), .mret(mret),
        .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mepc_in(mepc_in),
        .pending(pending), .trap_rup(trap_rup), .cause_intr(cause_intr),
        .cause_code(cause_code), .epc_out(epc_out), .tval_out(tval_out),
        .insert_pc(insert_pc), .priv_pc(priv_pc), .busy(busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [15:0] take, nxt;
        int e, i;
        if (RST) begin
            m_inflight = 0; m_commit = 0; m_ret = 0; m_intr = 0;
            m_code = 0; m_epc = 0; m_tval = 0; m_pend = 0; m_prev = 0;
            return;
        end
        take = 16'h0;
        if (m_commit && m_intr) take[m_code] = 1'b1;
        nxt = (m_pend & ~clear_pending & ~take) | (irq_src & ~m_prev);
        if (m_commit || m_ret) begin
            m_commit = 0;
            m_ret    = 0;
        end else if (m_inflight) begin
            if (exc_src != 0 && m_intr) begin
                m_intr = 0; m_code = lowest(exc_src); m_epc = exc_pc; m_tval = exc_tval;
            end
            if (pipe_clear) begin
                m_inflight = 0;
                m_commit   = 1;
            end
        end else begin
            e = lowest(exc_src);
            i = global_ie ? lowest(m_pend & irq_en) : -1;
            if (e >= 0) begin
                m_intr = 0; m_code = e; m_epc = exc_pc; m_tval = exc_tval; m_inflight = 1;
            end else if (i >= 0) begin
                m_intr = 1; m_code = i; m_epc = exc_pc; m_tval = 0; m_inflight = 1;
            end else if (mret) begin
                m_ret = 1;
            end
        end
        m_pend = nxt;
        m_prev = irq_src;
    endtask

    task automatic compare();
        logic [31:0] base, target;
        chk("pending",    pending,    m_pend);
        chk("busy",       busy,       m_inflight | m_commit | m_ret);
        chk("trap_rup",   trap_rup,   m_commit);
        chk("insert_pc",  insert_pc,  m_commit | m_ret);
        chk("cause_intr", cause_intr, m_intr);
        chk("cause_code", cause_code, m_code[3:0]);
        chk("epc_out",    epc_out,    m_epc);
        chk("tval_out",   tval_out,   m_tval);
        if (m_commit) begin
            base   = mtvec_base & 32'hFFFF_FFFC;
            target = (mtvec_mode == 2'd1 && m_intr) ? base + 32'(m_code * 4) : base;
            chk("priv_pc_trap", priv_pc, target);
        end else if (m_ret) begin
            chk("priv_pc_ret", priv_pc, mepc_in);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        compare();
    endtask

    initial begin
        RST = 1; irq_src = 0; irq_en = 0; global_ie = 0; clear_pending = 0;
        exc_src = 0; exc_pc = 0; exc_tval = 0; pipe_clear = 1; mret = 0;
        mtvec_base = 0; mtvec_mode = 0; mepc_in = 0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_priv_pc", priv_pc, 0);
        chk("rst_epc", epc_out, 0);

        // Vectored interrupt 7
        RST = 0; irq_en = 16'hFFFF; global_ie = 1; mtvec_base = 32'h100; mtvec_mode = 1;
        step();
        irq_src = 16'h0080; step();
        chk("t1_pending_set", pending, 16'h0080);
        step();
        chk("t1_cause", {cause_intr, cause_code}, {1'b1, 4'd7});
        step();
        chk("t1_strobes", {trap_rup, insert_pc}, 2'b11);
        chk("t1_priv_pc", priv_pc, 32'h11C);
        step();
        chk("t1_pending_clr", pending, 16'h0000);

        // Direct mode
        irq_src = 0; mtvec_mode = 0; step();
        irq_src = 16'h0080; step(); step(); step();
        chk("t2_direct_pc", priv_pc, 32'h100);
        step();

        // Vector address wraps
        irq_src = 0; mtvec_mode = 1; mtvec_base = 32'hFFFF_FFF1; step();
        irq_src = 16'h0080; step(); step(); step();
        chk("t2_wrap_pc", priv_pc, 32'h0000_000C);
        step();

        // Global disable: pending stays, no trap
        irq_src = 0; global_ie = 0; mtvec_base = 32'h100; step();
        irq_src = 16'h0080; step(); step(); step();
        chk("t2_gie_pending", pending, 16'h0080);
        chk("t2_gie_busy", busy, 0);

        // Exception beats interrupt, interrupt taken after return
        clear_pending = 16'h0080; irq_src = 0; step();
        chk("t3_sw_clear", pending, 0);
        clear_pending = 0; irq_src = 16'h0008; step();
        global_ie = 1; exc_src = 16'h0004; exc_pc = 32'h2000; exc_tval = 32'hDEAD; step();
        chk("t3_cause", {cause_intr, cause_code}, {1'b0, 4'd2});
        chk("t3_epc", epc_out, 32'h2000);
        chk("t3_tval", tval_out, 32'hDEAD);
        exc_src = 0; global_ie = 0; step();
        chk("t3_commit", trap_rup, 1);
        chk("t3_pc", priv_pc, 32'h100);
        chk("t3_irq_kept", pending, 16'h0008);
        step();
        mret = 1; mepc_in = 32'h3004; step();
        chk("t5_ret", {insert_pc, trap_rup}, 2'b10);
        chk("t5_ret_pc", priv_pc, 32'h3004);
        mret = 0; global_ie = 1; step(); step();
        chk("t3_irq_cause", {cause_intr, cause_code}, {1'b1, 4'd3});
        step();
        chk("t3_irq_pc", priv_pc, 32'h10C);
        step();
        chk("t3_irq_clr", pending, 0);

        // Exception preempts interrupt during drain
        pipe_clear = 0; irq_src = 16'h0200; step(); step();
        chk("t4_intr", {cause_intr, cause_code}, {1'b1, 4'd9});
        step(); step();
        exc_src = 16'h0020; exc_pc = 32'h4000; exc_tval = 32'h55; step();
        chk("t4_relatch", {cause_intr, cause_code}, {1'b0, 4'd5});
        chk("t4_epc", epc_out, 32'h4000);
        exc_src = 0; pipe_clear = 1; step();
        chk("t4_commit", {trap_rup, cause_intr, cause_code}, {1'b1, 1'b0, 4'd5});
        global_ie = 0; step();
        chk("t4_irq_kept", pending, 16'h0200);

        // mret with an exception: trap only
        exc_src = 16'h0002; mret = 1; step();
        chk("t5_trap_only", {busy, insert_pc, cause_code}, {1'b1, 1'b0, 4'd1});
        exc_src = 0; mret = 0; step();
        chk("t5_commit", trap_rup, 1);
        step();

        // Reset during DRAIN
        pipe_clear = 0; exc_src = 16'h0001; step();
        chk("t6_drain", busy, 1);
        exc_src = 0; RST = 1; step();
        chk("t6_rst", {busy, trap_rup, insert_pc, pending}, 19'h0);
        RST = 0; irq_src = 0; pipe_clear = 1; step();

        // Edge beats clear
        irq_src = 16'h0010; clear_pending = 16'h0010; step();
        chk("t6_edge_wins", pending, 16'h0010);
        clear_pending = 0; step();

        // Randomized
        for (int n = 0; n < 3000; n++) begin
            RST           = ($urandom_range(0, 199) == 0);
            irq_src       = irq_src ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) irq_en = 16'($urandom);
            global_ie     = ($urandom_range(0, 3) != 0);
            clear_pending = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
            exc_src       = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'h0;
            exc_pc        = $urandom;
            exc_tval      = $urandom;
            pipe_clear    = ($urandom_range(0, 3) != 0);
            mret          = ($urandom_range(0, 7) == 0);
            mtvec_base    = $urandom;
            mtvec_mode    = 2'($urandom_range(0, 3));
            mepc_in       = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priv_trap_sequencer.md
Name: priv_trap_sequencer

Overview:
Parametrised trap/interrupt sequencer for the privilege block. It generalises the fixed machine-mode interrupt/exception set to NUM_IRQ edge-latched interrupt sources and NUM_EXC exception sources. It adds vectored trap dispatch and an explicit drain handshake with the pipeline. It sits between the pipeline hazard logic and the CSR file, and produces one-cycle register-update strobes plus the PC redirect.

Parameters:
NUM_IRQ, 16, number of interrupt sources (2..32).
NUM_EXC, 16, number of exception sources (2..32).
XLEN, 32, data and address width.
VECTORED_EN, 1, when 0, vectored mode is ignored and all traps go to the base address.

Ports:
CLK  input  1  clock
RST  input  1  synchronous, active-high reset
irq_src  input  NUM_IRQ  raw interrupt lines; rising edge sets pending
irq_en  input  NUM_IRQ  per-source enable (mie image)
global_ie  input  1  mstatus.MIE
clear_pending  input  NUM_IRQ  software clear of pending bits
exc_src  input  NUM_EXC  exception flags from the pipeline, level
exc_pc  input  XLEN  PC of the faulting or next instruction
exc_tval  input  XLEN  trap value for an exception
pipe_clear  input  1  pipeline drained, safe to redirect
mret  input  1  return request, one-cycle pulse
mtvec_base  input  XLEN  trap vector base
mtvec_mode  input  2  0 = direct, 1 = vectored
mepc_in  input  XLEN  current mepc
pending  output  NUM_IRQ  latched pending bits (mip image)
trap_rup  output  1  one-cycle strobe: write mcause, mepc, mtval and mstatus
cause_intr  output  1  mcause interrupt bit
cause_code  output  CW  cause index, CW = $clog2(max(NUM_IRQ,NUM_EXC))
epc_out  output  XLEN  value to write to mepc
tval_out  output  XLEN  value to write to mtval
insert_pc  output  1  one-cycle PC redirect strobe
priv_pc  output  XLEN  redirect target
busy  output  1  state != IDLE

Behaviour:
- Reset: state = IDLE. pending, the irq_src history register, cause_intr, cause_code, epc_out, tval_out and priv_pc are all 0. trap_rup, insert_pc and busy are 0.
- Pending update, every cycle: pending <= (pending & ~clear_pending & ~taken) | (irq_src & ~irq_src_q).
  - A new edge wins over a clear or take in the same cycle.
  - taken is the one-hot of the committed IRQ, active in the COMMIT cycle only.
- Priority: any exc_src beats any interrupt. Among exceptions, the lowest index wins; among interrupts (pending & irq_en), the lowest index wins.
- An interrupt is eligible only when global_ie = 1.
- IDLE:
  - If |exc_src: latch cause_intr = 0, code, epc = exc_pc, tval = exc_tval; go to DRAIN.
  - Else if an interrupt is eligible: latch cause_intr = 1, code, epc = exc_pc, tval = 0; go to DRAIN.
  - Else if mret: go to RET.
  - A trap and mret in the same cycle: the trap wins and mret is dropped.
- DRAIN:
  - Hold the latched cause. If pipe_clear = 1, go to COMMIT.
  - If a new exception arrives while the latched cause is an interrupt, re-latch it as that exception; the interrupt stays pending.
  - If the latched cause is an exception, later exceptions are ignored.
  - mret is ignored.
- COMMIT, one cycle:
  - trap_rup = 1 and insert_pc = 1.
  - The taken IRQ pending bit is cleared.
  - Go to IDLE.
- RET, one cycle: insert_pc = 1, priv_pc = mepc_in, trap_rup = 0; go to IDLE.
- priv_pc in COMMIT:
  - base = {mtvec_base[XLEN-1:2], 2'b00}.
  - If VECTORED_EN, mtvec_mode == 1 and cause_intr: base + (cause_code << 2), truncated to XLEN so wrap-around is permitted.
  - Otherwise: base.
  - mtvec_mode values 2 and 3 are treated as direct.
- Latency: trap detected in cycle T with pipe_clear already 1 gives DRAIN at T+1 and COMMIT (strobes) at T+2. Each cycle of pipe_clear = 0 in DRAIN adds one cycle. mret in T gives insert_pc at T+1.
- Output hold: cause, epc and tval outputs hold their last latched values in all states. Strobes are 0 outside COMMIT and RET.
- RST asserted in any state returns to the reset condition on the next edge; in-flight traps and pending bits are discarded.
- Disabled or masked pending bits remain set until cleared.

Decomposition:
- Shared package priv_trap_pkg holds:
  - the state enum trap_state_t {IDLE, DRAIN, COMMIT, RET};
  - the mtvec mode constants MTVEC_DIRECT = 0 and MTVEC_VECTORED = 1;
  - the function for cause-code width.
- One sub-module, priv_prio_enc: parametrised lowest-index-first priority encoder with outputs valid, index and one-hot. It is instantiated twice, once for exceptions and once for interrupts.

Test Plan:
1. Reset, then a rising edge on irq_src[7] with irq_en[7] = 1, global_ie = 1, pipe_clear = 1, mtvec_base = 0x100, mode 1 -> at T+2: trap_rup = 1, insert_pc = 1, cause_intr = 1, code = 7, priv_pc = 0x11C; pending[7] = 0 afterwards.
2. Same stimulus with mode 0 -> priv_pc = 0x100. Same stimulus with global_ie = 0 -> no trap, pending[7] stays 1.
3. exc_src[2] and eligible IRQ 3 in the same cycle, exc_pc = 0x2000, exc_tval = 0xDEAD -> exception taken with cause_intr = 0, code = 2, epc_out = 0x2000, tval_out = 0xDEAD; IRQ 3 is taken after the return.
4. Interrupt latched, pipe_clear held 0 for 4 cycles, exc_src[5] arrives in DRAIN -> commit reports exception 5 when pipe_clear rises; the IRQ stays pending.
5. mret with mepc_in = 0x3004 -> next cycle insert_pc = 1, priv_pc = 0x3004, trap_rup = 0; mret coincident with an exception -> trap only.
6. RST asserted during DRAIN -> next cycle busy = 0, pending = 0, no strobes. Also: an irq_src edge in the same cycle as clear_pending -> the bit remains set.
